// File: rtl/prog_loader.sv
// Program loader: assembles UART bytes (low byte first) into instruction words, writes them to
// program memory from address 0 and pulses start on the HALT word. Optional macro LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter int len_data   = 16,
  parameter int len_addr   = 11,
  parameter int len_opcode = 5,
  parameter int len_byte   = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rx_done,
  input  logic [len_byte-1:0] rx_data,
  input  logic                reload,
  output logic [len_addr-1:0] prog_addr,
  output logic [len_data-1:0] prog_data,
  output logic                prog_wr,
  output logic                start,
  output logic                loading,
  output logic                error,
  output logic [len_addr:0]   word_count
);

  typedef enum logic [2:0] {
    WAIT_LO,
    WAIT_HI,
    WRITE,
    START,
    RUN,
    ERROR
`ifdef LOADER_CHECKSUM_EN
    , CHECK
`endif
  } state_t;

  state_t state, next_state;

  logic [len_addr-1:0] wr_ptr;
  logic [len_byte-1:0] lo_byte;
  logic                is_halt;
  logic                restart;
  logic                byte_taken;
  logic                nxt_prog_wr, nxt_start, nxt_loading, nxt_error;
`ifdef LOADER_CHECKSUM_EN
  logic [len_byte-1:0] xsum;
`endif

  // The word under write sits in prog_data during WRITE, so HALT is decoded from there.
  assign is_halt    = (prog_data[len_data-1 -: len_opcode] == '0);
  assign byte_taken = rx_done && !reload && (state == WAIT_LO || state == WAIT_HI);

  always_comb begin
    restart = 1'b0;
    case (state)
      WAIT_LO, WAIT_HI, RUN, ERROR: restart = reload;
`ifdef LOADER_CHECKSUM_EN
      CHECK:                        restart = reload;
`endif
      default:                      restart = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= WAIT_LO;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      WAIT_LO: if (reload) next_state = WAIT_LO;
               else if (rx_done) next_state = WAIT_HI;
      WAIT_HI: if (reload) next_state = WAIT_LO;
               else if (rx_done) next_state = WRITE;
      WRITE: begin
        if (is_halt)
`ifdef LOADER_CHECKSUM_EN
          next_state = CHECK;
`else
          next_state = START;
`endif
        else if (wr_ptr == {len_addr{1'b1}}) next_state = ERROR;
        else next_state = WAIT_LO;
      end
      START:      next_state = RUN;
      RUN, ERROR: if (reload) next_state = WAIT_LO;
`ifdef LOADER_CHECKSUM_EN
      CHECK: if (reload) next_state = WAIT_LO;
             else if (rx_done) next_state = (rx_data == xsum) ? START : ERROR;
`endif
      default: next_state = WAIT_LO;
    endcase
  end

  // Status outputs are registered, so they are decoded from the state being entered.
  always_comb begin
    nxt_prog_wr = (next_state == WRITE);
    nxt_start   = (next_state == START);
    nxt_error   = (next_state == ERROR);
    nxt_loading = (next_state == WAIT_LO) || (next_state == WAIT_HI) || (next_state == WRITE);
`ifdef LOADER_CHECKSUM_EN
    nxt_loading = nxt_loading || (next_state == CHECK);
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prog_wr <= 1'b0;
      start   <= 1'b0;
      error   <= 1'b0;
      loading <= 1'b1;
    end else begin
      prog_wr <= nxt_prog_wr;
      start   <= nxt_start;
      error   <= nxt_error;
      loading <= nxt_loading;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      word_count <= '0;
      lo_byte    <= '0;
      prog_addr  <= '0;
      prog_data  <= '0;
    end else begin
      if (restart) begin
        wr_ptr     <= '0;
        word_count <= '0;
      end else if (state == WRITE) begin
        wr_ptr     <= wr_ptr + 1'b1;
        word_count <= word_count + 1'b1;
      end
      if (byte_taken && state == WAIT_LO) lo_byte <= rx_data;
      if (byte_taken && state == WAIT_HI) begin
        prog_addr <= wr_ptr;
        prog_data <= {rx_data, lo_byte};
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          xsum <= '0;
    else if (restart)    xsum <= '0;
    else if (byte_taken) xsum <= xsum ^ rx_data;
  end
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader: a default-size instance plus a len_addr=2
// instance sharing the same stimulus, used for the overflow case.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rx_done = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        reload = 1'b0;

  logic [10:0] prog_addr;
  logic [15:0] prog_data;
  logic        prog_wr, start, loading, error;
  logic [11:0] word_count;

  logic [1:0]  s_prog_addr;
  logic [15:0] s_prog_data;
  logic        s_prog_wr, s_start, s_loading, s_error;
  logic [2:0]  s_word_count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [31:0] wa[$];
  logic [31:0] wd[$];
  int start_cnt, start_cyc, last_wr_cyc;
  int s_wr_cnt, s_start_cnt;
  logic [31:0] s_last_addr, s_last_data;

  prog_loader u_dut (
    .clk(clk), .reset(reset), .rx_done(rx_done), .rx_data(rx_data), .reload(reload),
    .prog_addr(prog_addr), .prog_data(prog_data), .prog_wr(prog_wr), .start(start),
    .loading(loading), .error(error), .word_count(word_count)
  );

  prog_loader #(.len_addr(2)) u_small (
    .clk(clk), .reset(reset), .rx_done(rx_done), .rx_data(rx_data), .reload(reload),
    .prog_addr(s_prog_addr), .prog_data(s_prog_data), .prog_wr(s_prog_wr), .start(s_start),
    .loading(s_loading), .error(s_error), .word_count(s_word_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Log every write and start pulse seen by either instance.
  always @(negedge clk) begin
    if (prog_wr) begin
      wa.push_back(32'(prog_addr));
      wd.push_back(32'(prog_data));
      last_wr_cyc = cyc;
    end
    if (start) begin
      start_cnt++;
      start_cyc = cyc;
    end
    if (s_prog_wr) begin
      s_wr_cnt++;
      s_last_addr = 32'(s_prog_addr);
      s_last_data = 32'(s_prog_data);
    end
    if (s_start) s_start_cnt++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input int gap);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic applyReload();
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  task automatic applyReset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic clearLog();
    wa.delete();
    wd.delete();
    start_cnt = 0;
    start_cyc = -100;
    last_wr_cyc = -200;
    s_wr_cnt = 0;
    s_start_cnt = 0;
    s_last_addr = 32'hFFFF_FFFF;
    s_last_data = 32'hFFFF_FFFF;
  endtask

  function automatic logic [31:0] logAddr(input int i);
    return (wa.size() > i) ? wa[i] : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] logData(input int i);
    return (wd.size() > i) ? wd[i] : 32'hFFFF_FFFF;
  endfunction

  initial begin
    clearLog();
    #12;
    $display("[TB] reset state");
    checkOutput("rst_prog_wr", 32'(prog_wr), 32'd0);
    checkOutput("rst_start", 32'(start), 32'd0);
    checkOutput("rst_error", 32'(error), 32'd0);
    checkOutput("rst_loading", 32'(loading), 32'd1);
    checkOutput("rst_word_count", 32'(word_count), 32'd0);
    checkOutput("rst_prog_addr", 32'(prog_addr), 32'd0);
    checkOutput("rst_prog_data", 32'(prog_data), 32'd0);
    @(negedge clk);
    reset = 1'b1;

`ifdef LOADER_CHECKSUM_EN
    $display("[TB] checksum accepted");
    clearLog();
    applyStimulus(8'h01, 2); applyStimulus(8'h08, 2);
    applyStimulus(8'h00, 2); applyStimulus(8'h00, 2);
    idle(3);
    checkOutput("ck_writes", 32'(wa.size()), 32'd2);
    checkOutput("ck_wait_start", 32'(start_cnt), 32'd0);
    checkOutput("ck_wait_loading", 32'(loading), 32'd1);
    applyStimulus(8'h09, 2);
    idle(3);
    checkOutput("ck_ok_start", 32'(start_cnt), 32'd1);
    checkOutput("ck_ok_error", 32'(error), 32'd0);
    checkOutput("ck_ok_loading", 32'(loading), 32'd0);

    $display("[TB] checksum rejected");
    applyReload();
    clearLog();
    applyStimulus(8'h01, 2); applyStimulus(8'h08, 2);
    applyStimulus(8'h00, 2); applyStimulus(8'h00, 2);
    applyStimulus(8'h0A, 2);
    idle(3);
    checkOutput("ck_bad_error", 32'(error), 32'd1);
    checkOutput("ck_bad_start", 32'(start_cnt), 32'd0);
    checkOutput("ck_bad_loading", 32'(loading), 32'd0);
`else
    $display("[TB] basic three-word program");
    clearLog();
    applyStimulus(8'h01, 2);
    applyStimulus(8'h08, 0);
    #1;
    checkOutput("wr_after_hi", 32'(prog_wr), 32'd1);
    checkOutput("wr_after_hi_addr", 32'(prog_addr), 32'd0);
    checkOutput("wr_after_hi_data", 32'(prog_data), 32'h0801);
    applyStimulus(8'h05, 2); applyStimulus(8'h18, 2);
    applyStimulus(8'h00, 2); applyStimulus(8'h00, 2);
    idle(4);
    checkOutput("p1_nwrites", 32'(wa.size()), 32'd3);
    checkOutput("p1_addr1", logAddr(1), 32'd1);
    checkOutput("p1_data1", logData(1), 32'h1805);
    checkOutput("p1_addr2", logAddr(2), 32'd2);
    checkOutput("p1_data2", logData(2), 32'h0000);
    checkOutput("p1_start_cnt", 32'(start_cnt), 32'd1);
    checkOutput("p1_start_delay", 32'(start_cyc - last_wr_cyc), 32'd1);
    checkOutput("p1_word_count", 32'(word_count), 32'd3);
    checkOutput("p1_loading", 32'(loading), 32'd0);

    $display("[TB] reset mid-word");
    applyStimulus(8'hAA, 2);
    applyReset();
    clearLog();
    applyStimulus(8'h34, 2); applyStimulus(8'h12, 2);
    applyStimulus(8'h00, 2); applyStimulus(8'h00, 2);
    idle(4);
    checkOutput("p2_addr0", logAddr(0), 32'd0);
    checkOutput("p2_data0", logData(0), 32'h1234);
    checkOutput("p2_addr1", logAddr(1), 32'd1);
    checkOutput("p2_start_cnt", 32'(start_cnt), 32'd1);
    checkOutput("p2_start_delay", 32'(start_cyc - last_wr_cyc), 32'd1);

    $display("[TB] bytes ignored in RUN, then reload");
    clearLog();
    applyStimulus(8'h11, 2); applyStimulus(8'h22, 2);
    applyStimulus(8'h33, 2); applyStimulus(8'h44, 2);
    idle(3);
    checkOutput("run_no_write", 32'(wa.size()), 32'd0);
    checkOutput("run_no_start", 32'(start_cnt), 32'd0);
    checkOutput("run_word_count", 32'(word_count), 32'd2);
    applyReload();
    idle(1);
    checkOutput("rl_loading", 32'(loading), 32'd1);
    checkOutput("rl_word_count", 32'(word_count), 32'd0);
    applyStimulus(8'h00, 2); applyStimulus(8'h00, 2);
    idle(4);
    checkOutput("rl_nwrites", 32'(wa.size()), 32'd1);
    checkOutput("rl_addr0", logAddr(0), 32'd0);
    checkOutput("rl_data0", logData(0), 32'h0000);
    checkOutput("rl_start_cnt", 32'(start_cnt), 32'd1);

    $display("[TB] reload and rx_done together in WAIT_HI");
    applyReload();
    applyStimulus(8'h55, 2);
    clearLog();
    @(negedge clk);
    rx_data = 8'h66;
    rx_done = 1'b1;
    reload  = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    reload  = 1'b0;
    idle(3);
    checkOutput("sim_no_write", 32'(wa.size()), 32'd0);
    checkOutput("sim_loading", 32'(loading), 32'd1);
    applyStimulus(8'h78, 2); applyStimulus(8'h56, 2);
    idle(3);
    checkOutput("sim_nwrites", 32'(wa.size()), 32'd1);
    checkOutput("sim_addr0", logAddr(0), 32'd0);
    checkOutput("sim_data0", logData(0), 32'h5678);
    checkOutput("sim_word_count", 32'(word_count), 32'd1);
    checkOutput("sim_no_start", 32'(start_cnt), 32'd0);

    $display("[TB] overflow on the len_addr=2 instance");
    applyReset();
    clearLog();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(8'(i), 2);
      applyStimulus(8'h08, 2);
    end
    idle(3);
    checkOutput("ov_nwrites", 32'(s_wr_cnt), 32'd4);
    checkOutput("ov_last_addr", s_last_addr, 32'd3);
    checkOutput("ov_last_data", s_last_data, 32'h0803);
    checkOutput("ov_error", 32'(s_error), 32'd1);
    checkOutput("ov_loading", 32'(s_loading), 32'd0);
    checkOutput("ov_word_count", 32'(s_word_count), 32'd4);
    applyStimulus(8'h04, 2); applyStimulus(8'h08, 2);
    idle(3);
    checkOutput("ov_no_fifth", 32'(s_wr_cnt), 32'd4);
    checkOutput("ov_no_start", 32'(s_start_cnt), 32'd0);
    checkOutput("ov_big_count", 32'(word_count), 32'd5);
    applyReload();
    idle(1);
    checkOutput("ov_rl_error", 32'(s_error), 32'd0);
    checkOutput("ov_rl_loading", 32'(s_loading), 32'd1);
    checkOutput("ov_rl_word_count", 32'(s_word_count), 32'd0);
    clearLog();
    applyStimulus(8'h00, 2); applyStimulus(8'h09, 2);
    idle(3);
    checkOutput("ov_rl_nwrites", 32'(s_wr_cnt), 32'd1);
    checkOutput("ov_rl_addr", s_last_addr, 32'd0);
    checkOutput("ov_rl_data", s_last_data, 32'h0900);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
